axis_fir_stim_gen: RTL and testbench

//  Synthesisable AXI4-Stream test-pattern source for exercising the FIR filter in the sp701 block design.

---
 rtl/axis_stim_pkg.sv | 31 +++
 rtl/stim_pattern_gen.sv | 41 ++++
 rtl/axis_fir_stim_gen.sv | 188 ++++++++++++++++++
 tb/tb_axis_fir_stim_gen.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_stim_pkg.sv
// -----------------------------------------------------------------------------
// axis_stim_pkg
// Shared definitions for the AXI4-Stream FIR stimulus source:
//   mode_t    : pattern selection encodings
//   state_t   : sequencer states
//   LFSR_*    : Galois LFSR taps (x^16+x^14+x^13+x^11+1) and seed
//   lfsr_next : one right-shift Galois step
// -----------------------------------------------------------------------------
package axis_stim_pkg;

  typedef enum logic [1:0] {
    MODE_IMPULSE = 2'd0,
    MODE_STEP    = 2'd1,
    MODE_RAMP    = 2'd2,
    MODE_SQUARE  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/stim_pattern_gen.sv
// -----------------------------------------------------------------------------
// stim_pattern_gen
// Combinational test-pattern value for sample index n.
// Ports:
//   mode   in  2       pattern select (impulse/step/ramp/square)
//   n      in  N_W     sample index within the packet
//   sample out DATA_W  two's complement pattern value
// -----------------------------------------------------------------------------
module stim_pattern_gen
  import axis_stim_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          N_W      = 6,
  parameter int unsigned AMP      = 32'h4000,
  parameter int unsigned HALF_PER = 8
) (
  input  logic [1:0]        mode,
  input  logic [N_W-1:0]    n,
  output logic [DATA_W-1:0] sample
);

  logic [DATA_W-1:0] amp_t;
  logic              half_odd;

  assign amp_t = DATA_W'(AMP);

  // Odd half-period index selects the negative half of the square wave.
  assign half_odd = ((32'(n) / HALF_PER) % 32'd2) == 32'd1;

  always_comb begin
    sample = '0;
    case (mode_t'(mode))
      MODE_IMPULSE: sample = (n == '0) ? amp_t : '0;
      MODE_STEP:    sample = amp_t;
      MODE_RAMP:    sample = DATA_W'(n);
      MODE_SQUARE:  sample = half_odd ? -amp_t : amp_t;
      default:      sample = '0;
    endcase
  end

endmodule

// File: rtl/axis_fir_stim_gen.sv
// -----------------------------------------------------------------------------
// axis_fir_stim_gen
// AXI4-Stream test-pattern source feeding the FIR s_axis port. After reset it
// waits RST_HOLD+1 cycles, then on each accepted start emits one packet of
// PKT_LEN samples per channel, channels interleaved and tagged on tid.
// Optional feature macro: AXIS_STIM_NOISE_EN adds signed 8-bit LFSR noise to
// every beat; when undefined no LFSR logic is built.
// Reset must be released synchronously to clk (upstream synchroniser).
// Ports:
//   clk            in   1       system clock
//   reset          in   1       async active-high reset
//   start          in   1       begin one packet (IDLE only)
//   mode           in   2       pattern select, latched on accepted start
//   m_axis_tdata   out  DATA_W  sample
//   m_axis_tvalid  out  1       sample valid
//   m_axis_tready  in   1       downstream ready
//   m_axis_tlast   out  1       last beat of packet
//   m_axis_tid     out  TID_W   channel of current beat
//   busy           out  1       high in HOLD and RUN
//   done           out  1       pulse after final handshake
//   pkt_count      out  16      packets completed since reset
//
// state   | meaning
// ST_HOLD | post-reset quiet period, start ignored
// ST_IDLE | waiting for start
// ST_RUN  | streaming beats of one packet
// -----------------------------------------------------------------------------
module axis_fir_stim_gen
  import axis_stim_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          NUM_CH   = 2,
  parameter int          PKT_LEN  = 64,
  parameter int unsigned AMP      = 32'h4000,
  parameter int unsigned HALF_PER = 8,
  parameter int          RST_HOLD = 4,
  localparam int         TID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [TID_W-1:0]  m_axis_tid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkt_count
);

  localparam int N_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int H_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  localparam logic [TID_W-1:0] CH_LAST   = TID_W'(NUM_CH - 1);
  localparam logic [N_W-1:0]   N_LAST    = N_W'(PKT_LEN - 1);
  localparam logic [H_W-1:0]   HOLD_LAST = H_W'(RST_HOLD);

  state_t            state;
  logic [H_W-1:0]    hold_cnt;
  logic [1:0]        mode_q;
  logic [N_W-1:0]    n_q;

  logic              hs;
  logic [1:0]        mode_sel;
  logic [N_W-1:0]    n_nxt;
  logic [TID_W-1:0]  ch_nxt;
  logic              tlast_nxt;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] tdata_nxt;

  assign hs = m_axis_tvalid && m_axis_tready;

  // Position of the beat that will be presented next: first beat of a packet
  // when idle, otherwise the successor of the current beat.
  always_comb begin
    mode_sel = mode;
    n_nxt    = '0;
    ch_nxt   = '0;
    if (state == ST_RUN) begin
      mode_sel = mode_q;
      if (m_axis_tid == CH_LAST) begin
        n_nxt  = n_q + N_W'(1);
        ch_nxt = '0;
      end else begin
        n_nxt  = n_q;
        ch_nxt = m_axis_tid + TID_W'(1);
      end
    end
  end

  assign tlast_nxt = (n_nxt == N_LAST) && (ch_nxt == CH_LAST);

  stim_pattern_gen #(
    .DATA_W   (DATA_W),
    .N_W      (N_W),
    .AMP      (AMP),
    .HALF_PER (HALF_PER)
  ) u_pattern (
    .mode   (mode_sel),
    .n      (n_nxt),
    .sample (pat)
  );

`ifdef AXIS_STIM_NOISE_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_adv;
  logic [7:0]  noise_lo;

  assign lfsr_adv = lfsr_next(lfsr_q);
  // First beat of a packet uses the seed; each later beat the advanced state.
  assign noise_lo  = (state == ST_RUN) ? lfsr_adv[7:0] : LFSR_SEED[7:0];
  assign tdata_nxt = pat + DATA_W'($signed(noise_lo));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (state == ST_IDLE && start) begin
      lfsr_q <= LFSR_SEED;
    end else if (state == ST_RUN && hs) begin
      lfsr_q <= lfsr_adv;
    end
  end
`else
  assign tdata_nxt = pat;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_HOLD;
      hold_cnt      <= '0;
      mode_q        <= MODE_IMPULSE;
      n_q           <= '0;
      m_axis_tid    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkt_count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + H_W'(1);
            busy     <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (start) begin
            state         <= ST_RUN;
            busy          <= 1'b1;
            mode_q        <= mode;
            n_q           <= n_nxt;
            m_axis_tid    <= ch_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tlast  <= tlast_nxt;
            m_axis_tvalid <= 1'b1;
          end
        end
        ST_RUN: begin
          if (hs) begin
            if (m_axis_tlast) begin
              state         <= ST_IDLE;
              busy          <= 1'b0;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              done          <= 1'b1;
              pkt_count     <= pkt_count + 16'd1;
            end else begin
              n_q          <= n_nxt;
              m_axis_tid   <= ch_nxt;
              m_axis_tdata <= tdata_nxt;
              m_axis_tlast <= tlast_nxt;
            end
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fir_stim_gen.sv
module tb_axis_fir_stim_gen;

`ifdef AXIS_STIM_NOISE_EN
  localparam bit NOISE_ON = 1'b1;
`else
  localparam bit NOISE_ON = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b1;

  logic        a_start = 1'b0, b_start = 1'b0;
  logic [1:0]  a_mode = 2'd0, b_mode = 2'd0;
  logic        a_tready = 1'b0, b_tready = 1'b0;
  logic [15:0] a_tdata, b_tdata;
  logic        a_tvalid, b_tvalid, a_tlast, b_tlast;
  logic [0:0]  a_tid, b_tid;
  logic        a_busy, b_busy, a_done, b_done;
  logic [15:0] a_pkt, b_pkt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Two channels, 4 samples per channel.
  axis_fir_stim_gen #(
    .DATA_W(16), .NUM_CH(2), .PKT_LEN(4), .AMP(32'h4000), .HALF_PER(8), .RST_HOLD(4)
  ) u_a (
    .clk(clk), .reset(reset), .start(a_start), .mode(a_mode),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
    .m_axis_tlast(a_tlast), .m_axis_tid(a_tid), .busy(a_busy), .done(a_done),
    .pkt_count(a_pkt)
  );

  // Single channel, 8 samples, square half period 2.
  axis_fir_stim_gen #(
    .DATA_W(16), .NUM_CH(1), .PKT_LEN(8), .AMP(32'h4000), .HALF_PER(2), .RST_HOLD(4)
  ) u_b (
    .clk(clk), .reset(reset), .start(b_start), .mode(b_mode),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .m_axis_tlast(b_tlast), .m_axis_tid(b_tid), .busy(b_busy), .done(b_done),
    .pkt_count(b_pkt)
  );

  // Expected noise on beat k of a packet: LFSR stepped k times from the seed,
  // low byte sign-extended; zero when the noise feature is not built.
  function automatic logic [15:0] noise(input int k);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < k; i++)
      l = {l[0], l[15], l[14] ^ l[0], l[13] ^ l[0], l[12], l[11] ^ l[0], l[10:1]};
    return NOISE_ON ? {{8{l[7]}}, l[7:0]} : 16'h0000;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({a_tvalid, a_tlast, a_busy, a_done, a_pkt, a_tdata, b_tvalid, b_busy, b_pkt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: a_valid=%b a_busy=%b a_pkt=%h a_data=%h b_valid=%b b_busy=%b required all 0",
               a_tvalid, a_busy, a_pkt, a_tdata, b_tvalid, b_busy);
    end
    reset   = 1'b0;
    a_start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      n_cmp++;
      if ({a_busy, a_tvalid} !== {(i <= 4), 1'b0}) begin
        n_err++;
        $display("FAIL hold_busy[%0d]: busy=%b valid=%b required busy=%b valid=0",
                 i, a_busy, a_tvalid, (i <= 4));
      end
    end
  endtask

  task automatic test_impulse();
    logic [15:0] pat [8] = '{16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [18:0] exp_v;
    a_mode = 2'd0; a_start = 1'b1; a_tready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_v = {1'b1, (i == 7), 1'(i % 2), 16'(pat[i] + noise(i))};
      n_cmp++;
      if ({a_tvalid, a_tlast, a_tid, a_tdata} !== exp_v) begin
        n_err++;
        $display("FAIL impulse_beat[%0d]: got v/l/id/data=%h required %h", i,
                 {a_tvalid, a_tlast, a_tid, a_tdata}, exp_v);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({a_tvalid, a_done, a_pkt} !== {1'b0, 1'b1, 16'd1}) begin
      n_err++;
      $display("FAIL impulse_done: valid=%b done=%b pkt=%0d required valid=0 done=1 pkt=1",
               a_tvalid, a_done, a_pkt);
    end
    @(negedge clk);
    n_cmp++;
    if (a_done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse_width: done=%b required 0", a_done);
    end
  endtask

  task automatic test_square();
    logic [15:0] pat [8] = '{16'h4000, 16'h4000, 16'hC000, 16'hC000,
                             16'h4000, 16'h4000, 16'hC000, 16'hC000};
    logic [18:0] exp_v;
    b_mode = 2'd3; b_start = 1'b1; b_tready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_v = {1'b1, (i == 7), 1'b0, 16'(pat[i] + noise(i))};
      n_cmp++;
      if ({b_tvalid, b_tlast, b_tid, b_tdata} !== exp_v) begin
        n_err++;
        $display("FAIL square_beat[%0d]: got v/l/id/data=%h required %h", i,
                 {b_tvalid, b_tlast, b_tid, b_tdata}, exp_v);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({b_tvalid, b_done, b_pkt} !== {1'b0, 1'b1, 16'd1}) begin
      n_err++;
      $display("FAIL square_done: valid=%b done=%b pkt=%0d required valid=0 done=1 pkt=1",
               b_tvalid, b_done, b_pkt);
    end
  endtask

  task automatic test_ramp_backpressure();
    int          j = 0;
    logic        prev_stall = 1'b0;
    logic [18:0] prev_v = '0;
    logic [18:0] cur;
    logic [18:0] exp_v;
    a_mode = 2'd2; a_start = 1'b1; a_tready = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    for (int c = 0; c < 80 && j < 8; c++) begin
      cur = {a_tvalid, a_tlast, a_tid, a_tdata};
      if (prev_stall) begin
        n_cmp++;
        if (cur !== prev_v) begin
          n_err++;
          $display("FAIL stall_hold[c%0d]: got %h required %h", c, cur, prev_v);
        end
      end
      a_tready = (c >= 6 && c <= 10) ? 1'b0 : (c % 2 == 0);
      if (a_tvalid && a_tready) begin
        exp_v = {1'b1, (j == 7), 1'(j % 2), 16'(16'(j / 2) + noise(j))};
        n_cmp++;
        if (cur !== exp_v) begin
          n_err++;
          $display("FAIL ramp_beat[%0d]: got %h required %h", j, cur, exp_v);
        end
        j++;
      end
      prev_stall = a_tvalid && !a_tready;
      prev_v     = cur;
      @(negedge clk);
    end
    n_cmp++;
    if (j != 8) begin
      n_err++;
      $display("FAIL ramp_beat_count: got %0d required 8 (cycle budget expired)", j);
    end
    n_cmp++;
    if ({a_tvalid, a_done, a_pkt} !== {1'b0, 1'b1, 16'd2}) begin
      n_err++;
      $display("FAIL ramp_done: valid=%b done=%b pkt=%0d required valid=0 done=1 pkt=2",
               a_tvalid, a_done, a_pkt);
    end
    a_tready = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    logic [18:0] exp_v;
    a_mode = 2'd1; a_start = 1'b1; a_tready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_tvalid, a_tid, a_pkt} !== {1'b1, 1'b1, 16'd2}) begin
      n_err++;
      $display("FAIL pre_reset_beat3: valid=%b id=%b pkt=%0d required valid=1 id=1 pkt=2",
               a_tvalid, a_tid, a_pkt);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_tvalid, a_tlast, a_busy, a_pkt} !== '0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b last=%b busy=%b pkt=%0d required all 0",
               a_tvalid, a_tlast, a_busy, a_pkt);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1 || i == 5) begin
        n_cmp++;
        if ({a_busy, a_tvalid} !== {(i == 1), 1'b0}) begin
          n_err++;
          $display("FAIL rehold_busy[%0d]: busy=%b valid=%b required busy=%b valid=0",
                   i, a_busy, a_tvalid, (i == 1));
        end
      end
    end
    a_mode = 2'd2; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_v = {1'b1, (i == 7), 1'(i % 2), 16'(16'(i / 2) + noise(i))};
      n_cmp++;
      if ({a_tvalid, a_tlast, a_tid, a_tdata} !== exp_v) begin
        n_err++;
        $display("FAIL restart_beat[%0d]: got %h required %h", i,
                 {a_tvalid, a_tlast, a_tid, a_tdata}, exp_v);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({a_done, a_pkt} !== {1'b1, 16'd1}) begin
      n_err++;
      $display("FAIL restart_done: done=%b pkt=%0d required done=1 pkt=1", a_done, a_pkt);
    end
  endtask

  task automatic test_noise();
    logic [15:0] exp_d;
    a_mode = 2'd1; a_start = 1'b1; a_tready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_d = 16'h4000 + noise(i);
      n_cmp++;
      if ({a_tvalid, a_tdata} !== {1'b1, exp_d}) begin
        n_err++;
        $display("FAIL noise_beat[%0d]: valid=%b data=%h required valid=1 data=%h",
                 i, a_tvalid, a_tdata, exp_d);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (a_pkt !== 16'd2) begin
      n_err++;
      $display("FAIL noise_pkt: pkt=%0d required 2", a_pkt);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp_v;
    b_mode = 2'd1; b_start = 1'b1; b_tready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_v = {1'b1, (i == 7), 1'b0, 16'(16'h4000 + noise(i))};
      n_cmp++;
      if ({b_tvalid, b_tlast, b_tid, b_tdata} !== exp_v) begin
        n_err++;
        $display("FAIL b2b_first_beat[%0d]: got %h required %h", i,
                 {b_tvalid, b_tlast, b_tid, b_tdata}, exp_v);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({b_tvalid, b_done, b_pkt} !== {1'b0, 1'b1, 16'd1}) begin
      n_err++;
      $display("FAIL b2b_done: valid=%b done=%b pkt=%0d required valid=0 done=1 pkt=1",
               b_tvalid, b_done, b_pkt);
    end
    b_mode = 2'd0; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_v = {1'b1, (i == 7), 1'b0, 16'(((i == 0) ? 16'h4000 : 16'h0000) + noise(i))};
      n_cmp++;
      if ({b_tvalid, b_tlast, b_tid, b_tdata} !== exp_v) begin
        n_err++;
        $display("FAIL b2b_second_beat[%0d]: got %h required %h", i,
                 {b_tvalid, b_tlast, b_tid, b_tdata}, exp_v);
      end
      b_start = (i == 3);
      @(negedge clk);
    end
    b_start = 1'b0;
    n_cmp++;
    if ({b_done, b_pkt} !== {1'b1, 16'd2}) begin
      n_err++;
      $display("FAIL b2b_second_done: done=%b pkt=%0d required done=1 pkt=2", b_done, b_pkt);
    end
    @(negedge clk);
    n_cmp++;
    if ({b_tvalid, b_busy} !== 2'b00) begin
      n_err++;
      $display("FAIL start_in_run_ignored: valid=%b busy=%b required 0 0", b_tvalid, b_busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_impulse();
    test_square();
    test_ramp_backpressure();
    test_reset_mid_packet();
    test_noise();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
